// File: rtl/output_arbiter_rr.sv
// Round-robin packet arbiter for one router output port; owner holds the link until last flit.
// Optional completed-packet counter enabled with ARBITER_PKT_COUNT_EN.
module output_arbiter_rr #(
  parameter int CHANNEL_NUMBER = 5,
  parameter int DATA_WIDTH     = 32,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [CHANNEL_NUMBER-1:0]          valid_i,
  input  logic [CHANNEL_NUMBER-1:0]          last_i,
  input  logic [CHANNEL_NUMBER*DATA_WIDTH-1:0] data_i,
  output logic [CHANNEL_NUMBER-1:0]          ready_o,
  output logic                               valid_o,
  output logic                               last_o,
  output logic [DATA_WIDTH-1:0]              data_o,
  input  logic                               ready_i,
`ifdef ARBITER_PKT_COUNT_EN
  output logic [CNT_WIDTH-1:0]               pkt_count_o,
`endif
  output logic [CHANNEL_NUMBER-1:0]          grant_o
);

  localparam int IW =
    (CHANNEL_NUMBER > 1) ? $clog2(CHANNEL_NUMBER) : 1;
  localparam logic [IW-1:0] LAST_CH = IW'(CHANNEL_NUMBER - 1);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] idx;
  logic          found;
  logic          done;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    idx     = '0;
    found   = 1'b0;
    done    = 1'b0;
    grant_o = '0;
    ready_o = '0;
    valid_o = 1'b0;
    last_o  = 1'b0;
    data_o  = '0;
    unique case (state_q)
      IDLE: begin
        // first requester at or after ptr, wrapping
        for (int i = 0; i < CHANNEL_NUMBER; i++) begin
          idx = IW'((int'(ptr_q) + i) % CHANNEL_NUMBER);
          if (!found && valid_i[idx]) begin
            found   = 1'b1;
            owner_d = idx;
          end
        end
        if (found) state_d = LOCKED;
      end
      LOCKED: begin
        for (int k = 0; k < CHANNEL_NUMBER; k++) begin
          if (owner_q == IW'(k)) begin
            grant_o[k] = 1'b1;
            valid_o    = valid_i[k];
            last_o     = last_i[k];
            data_o     = data_i[k*DATA_WIDTH +: DATA_WIDTH];
            ready_o[k] = ready_i;
          end
        end
        done = valid_o & ready_i & last_o;
        if (done) begin
          state_d = IDLE;
          ptr_d   = (owner_q == LAST_CH) ? '0 : owner_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef ARBITER_PKT_COUNT_EN
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (done) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign pkt_count_o = cnt_q;
`else
  // counter width still referenced so the parameter is not dangling
  if (CNT_WIDTH > 0) begin : g_no_pkt_count
  end
`endif

endmodule

// File: tb/tb_output_arbiter_rr.sv
// Bench for output_arbiter_rr: directed scenarios plus randomized traffic vs a packet-level model.
// Counter checks run when ARBITER_PKT_COUNT_EN is defined.
module tb_output_arbiter_rr;
  localparam int N  = 5;
  localparam int DW = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [N-1:0]  valid_in, last_in, ready_o, grant_o;
  logic [N*DW-1:0] data_in;
  logic          valid_o, last_o, ready_in;
  logic [DW-1:0] data_o;
`ifdef ARBITER_PKT_COUNT_EN
  logic [CW-1:0] pkt_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int m_owner = -1;
  int m_ptr   = 0;
  int m_cnt   = 0;

  always #5 clk = ~clk;

  output_arbiter_rr #(
    .CHANNEL_NUMBER(N),
    .DATA_WIDTH(DW),
    .CNT_WIDTH(CW)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .valid_i(valid_in),
    .last_i(last_in),
    .data_i(data_in),
    .ready_o(ready_o),
    .valid_o(valid_o),
    .last_o(last_o),
    .data_o(data_o),
    .ready_i(ready_in),
`ifdef ARBITER_PKT_COUNT_EN
    .pkt_count_o(pkt_count),
`endif
    .grant_o(grant_o)
  );

  // Packet-level reference: who owns the link, where the next search starts.
  function automatic void model_step();
    bit hit;
    int c;
    hit = 0;
    if (rst) begin
      m_owner = -1;
      m_ptr   = 0;
      m_cnt   = 0;
    end else if (m_owner < 0) begin
      for (int i = 0; i < N; i++) begin
        c = (m_ptr + i) % N;
        if (!hit && valid_in[c]) begin
          hit     = 1;
          m_owner = c;
        end
      end
    end else if (valid_in[m_owner] && ready_in && last_in[m_owner]) begin
      m_cnt   = (m_cnt + 1) % (1 << CW);
      m_ptr   = (m_owner + 1) % N;
      m_owner = -1;
    end
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_data(input int k, input logic [DW-1:0] v);
    data_in[k*DW +: DW] = v;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    valid_in = '0;
    last_in  = '0;
    ready_in = 1'b0;
    data_in  = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    valid_in = '1;
    last_in  = '1;
    ready_in = 1'b1;
    #1;
    n_tests++;
    if ({grant_o, ready_o, valid_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got g=%b r=%b v=%b want zeros",
               grant_o, ready_o, valid_o);
    end
    tick();
    rst      = 1'b0;
    valid_in = '0;
    #1;
    n_tests++;
    if (grant_o !== '0) begin
      n_fail++;
      $display("FAIL reset_idle_grant: got %b want 00000", grant_o);
    end
    tick();
  endtask

  task automatic test_rr_order();
    logic [N-1:0] exp_g [8];
    exp_g = '{5'b00000, 5'b00010, 5'b00000, 5'b00100,
              5'b00000, 5'b10000, 5'b00000, 5'b00010};
    do_reset();
    valid_in = 5'b10110;
    last_in  = '1;
    ready_in = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #1;
      n_tests++;
      if (grant_o !== exp_g[c]) begin
        n_fail++;
        $display("FAIL rr_order cyc %0d: got %b want %b",
                 c, grant_o, exp_g[c]);
      end
      tick();
    end
  endtask

  task automatic test_packet();
    do_reset();
    valid_in = 5'b01000;
    last_in  = '0;
    ready_in = 1'b1;
    set_data(3, 32'hA0);
    set_data(0, 32'h55);
    #1;
    n_tests++;
    if (grant_o !== 5'b00000) begin
      n_fail++;
      $display("FAIL pkt_arb_idle: got %b want 00000", grant_o);
    end
    tick();
    valid_in   = 5'b01001;
    last_in[0] = 1'b1;
    for (int f = 0; f < 4; f++) begin
      set_data(3, 32'hA0 + f);
      last_in[3] = (f == 3);
      #1;
      n_tests++;
      if (grant_o !== 5'b01000 || data_o !== 32'hA0 + f ||
          valid_o !== 1'b1 || ready_o !== 5'b01000) begin
        n_fail++;
        $display("FAIL pkt_flit %0d: got g=%b d=%h v=%b r=%b want g=01000 d=%h v=1 r=01000",
                 f, grant_o, data_o, valid_o, ready_o, 32'hA0 + f);
      end
      tick();
    end
    valid_in = 5'b00001;
    #1;
    n_tests++;
    if (grant_o !== 5'b00000) begin
      n_fail++;
      $display("FAIL pkt_gap: got %b want 00000", grant_o);
    end
    tick();
    #1;
    n_tests++;
    if (grant_o !== 5'b00001 || data_o !== 32'h55) begin
      n_fail++;
      $display("FAIL pkt_next_owner: got g=%b d=%h want g=00001 d=55",
               grant_o, data_o);
    end
    tick();
    valid_in = '0;
  endtask

  task automatic test_stall();
    int xfers;
    xfers = 0;
    do_reset();
    valid_in = 5'b00100;
    last_in  = '0;
    ready_in = 1'b1;
    set_data(2, 32'hB0);
    tick();
    for (int f = 0; f < 4; f++) begin
      set_data(2, 32'hB0 + f);
      last_in[2] = (f == 3);
      if (f == 1) begin
        ready_in = 1'b0;
        for (int s = 0; s < 3; s++) begin
          #1;
          n_tests++;
          if (data_o !== 32'hB1 || valid_o !== 1'b1 ||
              ready_o !== 5'b00000) begin
            n_fail++;
            $display("FAIL stall_hold %0d: got d=%h v=%b r=%b want d=b1 v=1 r=00000",
                     s, data_o, valid_o, ready_o);
          end
          if (valid_o && ready_in) xfers++;
          tick();
        end
        ready_in = 1'b1;
      end
      #1;
      n_tests++;
      if (data_o !== 32'hB0 + f || ready_o !== 5'b00100) begin
        n_fail++;
        $display("FAIL stall_flit %0d: got d=%h r=%b want d=%h r=00100",
                 f, data_o, ready_o, 32'hB0 + f);
      end
      if (valid_o && ready_in) xfers++;
      tick();
    end
    valid_in = '0;
    #1;
    n_tests++;
    if (xfers !== 4 || grant_o !== 5'b00000) begin
      n_fail++;
      $display("FAIL stall_count: got xfers=%0d g=%b want 4 g=00000",
               xfers, grant_o);
    end
  endtask

  task automatic test_drop();
    do_reset();
    valid_in = 5'b10000;
    last_in  = '0;
    ready_in = 1'b1;
    set_data(4, 32'hC0);
    tick();
    tick();
    valid_in = 5'b00010;
    for (int s = 0; s < 2; s++) begin
      #1;
      n_tests++;
      if (grant_o !== 5'b10000 || valid_o !== 1'b0 ||
          ready_o !== 5'b10000) begin
        n_fail++;
        $display("FAIL drop_hold %0d: got g=%b v=%b r=%b want g=10000 v=0 r=10000",
                 s, grant_o, valid_o, ready_o);
      end
      tick();
    end
    valid_in = 5'b10010;
    set_data(4, 32'hC1);
    last_in[4] = 1'b1;
    #1;
    n_tests++;
    if (valid_o !== 1'b1 || data_o !== 32'hC1 || last_o !== 1'b1) begin
      n_fail++;
      $display("FAIL drop_resume: got v=%b d=%h l=%b want v=1 d=c1 l=1",
               valid_o, data_o, last_o);
    end
    tick();
    valid_in = 5'b00010;
    tick();
    #1;
    n_tests++;
    if (grant_o !== 5'b00010) begin
      n_fail++;
      $display("FAIL drop_next: got %b want 00010", grant_o);
    end
    tick();
    valid_in = '0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    valid_in = 5'b01000;
    last_in  = '0;
    ready_in = 1'b1;
    set_data(3, 32'hD0);
    tick();
    tick();
    set_data(3, 32'hD1);
    valid_in = 5'b01010;
    #1;
    n_tests++;
    if (grant_o !== 5'b01000 || valid_o !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_pre: got g=%b v=%b want g=01000 v=1",
               grant_o, valid_o);
    end
    rst = 1'b1;
    #1;
    n_tests++;
    if (valid_o !== 1'b0 || grant_o !== '0 || ready_o !== '0) begin
      n_fail++;
      $display("FAIL rstmid_clear: got v=%b g=%b r=%b want zeros",
               valid_o, grant_o, ready_o);
    end
    tick();
    rst = 1'b0;
    tick();
    #1;
    n_tests++;
    if (grant_o !== 5'b00010) begin
      n_fail++;
      $display("FAIL rstmid_regrant: got %b want 00010", grant_o);
    end
    tick();
    valid_in = '0;
  endtask

  task automatic test_random();
    logic [N-1:0]  eg, er;
    logic          ev, el;
    logic [DW-1:0] ed;
    int            o;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      valid_in = N'($urandom);
      for (int k = 0; k < N; k++) begin
        last_in[k] = ($urandom_range(2) == 0);
        set_data(k, $urandom);
      end
      ready_in = ($urandom_range(3) != 0);
      rst      = ($urandom_range(99) == 0);
      #1;
      o  = rst ? -1 : m_owner;
      eg = '0;
      er = '0;
      ev = 1'b0;
      el = 1'b0;
      ed = '0;
      if (o >= 0) begin
        eg = N'(1) << o;
        ev = valid_in[o];
        el = last_in[o];
        ed = data_in[o*DW +: DW];
        er = ready_in ? eg : '0;
      end
      n_tests++;
      if (grant_o !== eg || ready_o !== er || valid_o !== ev) begin
        n_fail++;
        $display("FAIL rand_ctrl cyc %0d: got g=%b r=%b v=%b want g=%b r=%b v=%b",
                 c, grant_o, ready_o, valid_o, eg, er, ev);
      end
      if (o >= 0) begin
        n_tests++;
        if (data_o !== ed || last_o !== el) begin
          n_fail++;
          $display("FAIL rand_data cyc %0d: got d=%h l=%b want d=%h l=%b",
                   c, data_o, last_o, ed, el);
        end
      end
`ifdef ARBITER_PKT_COUNT_EN
      n_tests++;
      if (pkt_count !== CW'(rst ? 0 : m_cnt)) begin
        n_fail++;
        $display("FAIL rand_count cyc %0d: got %0d want %0d",
                 c, pkt_count, rst ? 0 : m_cnt);
      end
`endif
      tick();
    end
    rst      = 1'b0;
    valid_in = '0;
  endtask

`ifdef ARBITER_PKT_COUNT_EN
  task automatic test_pkt_count();
    do_reset();
    valid_in = 5'b00001;
    last_in  = 5'b00001;
    ready_in = 1'b1;
    repeat (34) tick();
    #1;
    n_tests++;
    if (pkt_count !== CW'(1)) begin
      n_fail++;
      $display("FAIL pkt_count_wrap: got %0d want 1", pkt_count);
    end
    valid_in = '0;
  endtask
`endif

  initial begin
    valid_in = '0;
    last_in  = '0;
    ready_in = 1'b0;
    data_in  = '0;
    @(negedge clk);
    test_reset();
    test_rr_order();
    test_packet();
    test_stall();
    test_drop();
    test_reset_mid();
    test_random();
`ifdef ARBITER_PKT_COUNT_EN
    test_pkt_count();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/output_arbiter_rr.md
OUTPUT_ARBITER_RR -- requirements
Module: output_arbiter_rr

Interface
- REQ-001: Parameter CHANNEL_NUMBER, default 5: number of competing input channels (0 local, 1 north, 2 east, 3 south, 4 west).
- REQ-002: Parameter DATA_WIDTH, default 32: flit payload width.
- REQ-003: Parameter CNT_WIDTH, default 16: packet counter width; used only under ARBITER_PKT_COUNT_EN.
- REQ-004: clk_i  input  1  single clock; all state updates on rising edge.
- REQ-005: rst_i  input  1  reset; asynchronous and active-high.
- REQ-006: valid_i  input  CHANNEL_NUMBER  per-channel flit valid; already qualified by that input's routing selector bit for this output.
- REQ-007: last_i  input  CHANNEL_NUMBER  per-channel end-of-packet flag; meaningful only with valid_i.
- REQ-008: data_i  input  CHANNEL_NUMBER*DATA_WIDTH  flattened payloads; channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- REQ-009: ready_o  output  CHANNEL_NUMBER  per-channel backpressure to inputs.
- REQ-010: valid_o  output  1  flit valid toward the output link.
- REQ-011: last_o  output  1  end-of-packet toward the output link.
- REQ-012: data_o  output  DATA_WIDTH  forwarded payload.
- REQ-013: ready_i  input  1  output link ready.
- REQ-014: grant_o  output  CHANNEL_NUMBER  one-hot owner of the output; all-zero when unowned.
- REQ-015: pkt_count_o  output  CNT_WIDTH  completed-packet count; present only under ARBITER_PKT_COUNT_EN.

Function
- REQ-016: The block SHALL implement a two-state FSM: IDLE (no owner) and LOCKED (one owner holds the output until its packet ends).
- REQ-017: In IDLE, valid_o, ready_o and grant_o SHALL be all-zero.
- REQ-018: In IDLE with any valid_i bit set, the block SHALL register the winner as the first set valid_i bit searched from index ptr upward, wrapping CHANNEL_NUMBER-1 to 0, and enter LOCKED next cycle (one-cycle arbitration latency).
- REQ-019: In LOCKED with owner s: grant_o = one-hot(s); valid_o = valid_i[s]; last_o = last_i[s]; data_o = data_i slice s; ready_o[s] = ready_i; all other ready_o bits 0 (combinational pass-through, zero added latency per flit).
- REQ-020: A transfer SHALL occur only when valid_o and ready_i are both high in the same cycle.
- REQ-021: On a transfer with last_o high, the FSM SHALL return to IDLE and ptr SHALL become s+1, wrapping CHANNEL_NUMBER-1 to 0.
- REQ-022: If valid_i[s] drops while LOCKED, the owner SHALL be held (no re-arbitration, no transfer) until its last flit transfers.
- REQ-023: Requests from non-owners SHALL be ignored while LOCKED; they see ready_o low.
- REQ-024: ptr SHALL be log2(CHANNEL_NUMBER) bits wide and change only on packet completion.
- REQ-025: A single-flit packet (last_i high on first flit) SHALL occupy exactly one LOCKED cycle when ready_i is high.

Reset
- REQ-026: Asserting rst_i SHALL immediately force IDLE, ptr = 0, owner cleared, grant_o = 0, valid_o = 0, ready_o = 0, and pkt_count_o = 0, including mid-packet; the partial packet is abandoned.
- REQ-027: After rst_i deasserts, the first arbitration SHALL start the search at channel 0.

Configuration
- REQ-028: Macro ARBITER_PKT_COUNT_EN defined: pkt_count_o exists and increments by 1 on every transfer with last_o high, wrapping from 2^CNT_WIDTH-1 to 0.
- REQ-029: Macro ARBITER_PKT_COUNT_EN undefined: pkt_count_o port and counter logic SHALL be absent; all other behaviour is identical.

Verification
- REQ-030: valid_i = 5'b10110, all last_i = 1, ready_i = 1 after reset -> grants in order ch1, ch2, ch4, ch1, each preceded by one IDLE cycle.
- REQ-031: ch3 sends 4-flit packet 0xA0..0xA3 while ch0 requests -> data_o 0xA0..0xA3 contiguous, grant_o = 5'b01000 throughout, ch0 granted only after 0xA3.
- REQ-032: ch2 owner, ready_i low for 3 cycles mid-packet -> data_o and valid_o held, no flit lost or duplicated, ready_o[2] = 0 during stall.
- REQ-033: ch4 owner drops valid_i[4] for 2 cycles while ch1 requests -> grant_o stays 5'b10000, no transfer until ch4 resumes.
- REQ-034: rst_i asserted during flit 2 of a 4-flit packet -> valid_o, grant_o, ready_o 0 in the same cycle; next grant after reset goes to lowest requesting channel.
- REQ-035: With ARBITER_PKT_COUNT_EN, CNT_WIDTH = 4, 17 single-flit packets -> pkt_count_o = 1 after wrap.
